// File: rtl/float_accumulator.sv
// float_accumulator: sequential IEEE-754 single-precision accumulator using an align/add/normalize FSM.
// Define FACC_ROUND_EN to round to nearest-even in NORM; the default build truncates.
module float_accumulator #(
    parameter int unsigned GUARD_BITS = 3,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               prod_valid_i,
    output logic               prod_ready_o,
    input  logic [31:0]        prod_data_i,
    input  logic               prod_last_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [31:0]        out_data_o,
    output logic [COUNT_W-1:0] term_count_o
);
    localparam int unsigned MW  = 24 + GUARD_BITS;  // significand plus guard bits
    localparam int unsigned SW  = MW + 1;           // room for the carry-out
    localparam int unsigned LZW = $clog2(MW + 1);

    typedef enum logic [2:0] {S_ACCEPT, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               acc_sign_q, acc_sign_d;
    logic [7:0]         acc_exp_q, acc_exp_d;
    logic [23:0]        acc_man_q, acc_man_d;
    logic               acc_inf_q, acc_inf_d;
    logic [31:0]        op_q, op_d;
    logic               last_q, last_d;
    logic               byp_q, byp_d;
    logic               a_sign_q, a_sign_d;
    logic               b_sign_q, b_sign_d;
    logic [7:0]         a_exp_q, a_exp_d;
    logic [MW-1:0]      a_man_q, a_man_d;
    logic [MW-1:0]      b_man_q, b_man_d;
    logic               sum_sign_q, sum_sign_d;
    logic [7:0]         sum_exp_q, sum_exp_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ready_q, ready_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [COUNT_W-1:0] term_count_q, term_count_d;

    // Align / add / normalize datapath temporaries
    logic [7:0]     op_exp, big_exp, diff;
    logic           op_big;
    logic [MW-1:0]  op_man, acc_mw, small_man, shifted;
    logic [SW-1:0]  add_sum;
    logic           add_sign;
    logic [LZW-1:0] lz;
    logic [MW-1:0]  norm;
    logic [9:0]     exp_w;
    logic [23:0]    man;
`ifdef FACC_ROUND_EN
    localparam logic [GUARD_BITS-1:0] HALF = GUARD_BITS'(1) << (GUARD_BITS - 1);
    logic [GUARD_BITS-1:0] grd;
    logic                  rnd_up;
    logic [24:0]           man_r;
`endif

    function automatic logic [31:0] pack(input logic inf, input logic s, input logic [7:0] e,
                                         input logic [22:0] f);
        if (inf) return {s, 8'hFF, 23'h0};
        if (e == 8'h00) return 32'h0;
        return {s, e, f};
    endfunction

    always_comb begin
        state_d      = state_q;
        acc_sign_d   = acc_sign_q;
        acc_exp_d    = acc_exp_q;
        acc_man_d    = acc_man_q;
        acc_inf_d    = acc_inf_q;
        op_d         = op_q;
        last_d       = last_q;
        byp_d        = byp_q;
        a_sign_d     = a_sign_q;
        b_sign_d     = b_sign_q;
        a_exp_d      = a_exp_q;
        a_man_d      = a_man_q;
        b_man_d      = b_man_q;
        sum_sign_d   = sum_sign_q;
        sum_exp_d    = sum_exp_q;
        sum_d        = sum_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        term_count_d = term_count_q;

        // Alignment: the operand with the larger exponent becomes A; exp=0 is a zero
        op_exp    = op_q[30:23];
        op_man    = (op_exp == 8'h00) ? '0 : {1'b1, op_q[22:0], {GUARD_BITS{1'b0}}};
        acc_mw    = {acc_man_q, {GUARD_BITS{1'b0}}};
        op_big    = op_exp > acc_exp_q;
        big_exp   = op_big ? op_exp : acc_exp_q;
        diff      = op_big ? (op_exp - acc_exp_q) : (acc_exp_q - op_exp);
        small_man = op_big ? acc_mw : op_man;
        shifted   = (diff >= 8'(MW)) ? '0 : (small_man >> diff);

        // Signed-magnitude add; the result takes the sign of the larger magnitude
        if (a_sign_q == b_sign_q) begin
            add_sum  = SW'(a_man_q) + SW'(b_man_q);
            add_sign = a_sign_q;
        end else if (a_man_q >= b_man_q) begin
            add_sum  = SW'(a_man_q) - SW'(b_man_q);
            add_sign = a_sign_q;
        end else begin
            add_sum  = SW'(b_man_q) - SW'(a_man_q);
            add_sign = b_sign_q;
        end

        lz = LZW'(MW);
        for (int i = 0; i < int'(MW); i++) begin
            if (sum_q[i]) lz = LZW'(int'(MW) - 1 - i);
        end
        if (sum_q[SW-1]) begin
            norm  = sum_q[SW-1:1];
            exp_w = {2'b00, sum_exp_q} + 10'd1;
        end else begin
            norm  = sum_q[MW-1:0] << lz;
            exp_w = {2'b00, sum_exp_q} - 10'(lz);
        end
        man = norm[MW-1:GUARD_BITS];
`ifdef FACC_ROUND_EN
        grd    = norm[GUARD_BITS-1:0];
        rnd_up = (grd > HALF) || ((grd == HALF) && man[0]);
        man_r  = {1'b0, man} + 25'(rnd_up);
        if (man_r[24]) begin
            man   = man_r[24:1];
            exp_w = exp_w + 10'd1;
        end else begin
            man   = man_r[23:0];
        end
`endif

        unique case (state_q)
            S_ACCEPT: begin
                if (prod_valid_i && ready_q) begin
                    op_d    = prod_data_i;
                    last_d  = prod_last_i;
                    count_d = (count_q == '1) ? count_q : count_q + COUNT_W'(1);
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                byp_d = 1'b0;
                if (acc_inf_q) begin
                    byp_d = 1'b1;
                end else if (op_exp == 8'hFF) begin
                    byp_d      = 1'b1;
                    acc_inf_d  = 1'b1;
                    acc_sign_d = op_q[31];
                end
                a_sign_d = op_big ? op_q[31] : acc_sign_q;
                b_sign_d = op_big ? acc_sign_q : op_q[31];
                a_exp_d  = big_exp;
                a_man_d  = op_big ? op_man : acc_mw;
                b_man_d  = shifted;
                state_d  = S_ADD;
            end
            S_ADD: begin
                sum_d      = add_sum;
                sum_sign_d = add_sign;
                sum_exp_d  = a_exp_q;
                state_d    = S_NORM;
            end
            S_NORM: begin
                if (!byp_q) begin
                    if ((norm == '0) || ($signed(exp_w) <= 10'sd0)) begin
                        acc_sign_d = 1'b0;
                        acc_exp_d  = 8'h00;
                        acc_man_d  = '0;
                    end else if ($signed(exp_w) >= 10'sd255) begin
                        acc_inf_d  = 1'b1;
                        acc_sign_d = sum_sign_q;
                    end else begin
                        acc_sign_d = sum_sign_q;
                        acc_exp_d  = exp_w[7:0];
                        acc_man_d  = man;
                    end
                end
                state_d = last_q ? S_DONE : S_ACCEPT;
                if (last_q) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = pack(acc_inf_d, acc_sign_d, acc_exp_d, acc_man_d[22:0]);
                    term_count_d = count_q;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    acc_sign_d  = 1'b0;
                    acc_exp_d   = 8'h00;
                    acc_man_d   = '0;
                    acc_inf_d   = 1'b0;
                    count_d     = '0;
                    state_d     = S_ACCEPT;
                end
            end
            default: state_d = S_ACCEPT;
        endcase

        ready_d = (state_d == S_ACCEPT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_ACCEPT;
            acc_sign_q   <= 1'b0;
            acc_exp_q    <= 8'h00;
            acc_man_q    <= '0;
            acc_inf_q    <= 1'b0;
            op_q         <= '0;
            last_q       <= 1'b0;
            byp_q        <= 1'b0;
            a_sign_q     <= 1'b0;
            b_sign_q     <= 1'b0;
            a_exp_q      <= 8'h00;
            a_man_q      <= '0;
            b_man_q      <= '0;
            sum_sign_q   <= 1'b0;
            sum_exp_q    <= 8'h00;
            sum_q        <= '0;
            count_q      <= '0;
            ready_q      <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            term_count_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_sign_q   <= acc_sign_d;
            acc_exp_q    <= acc_exp_d;
            acc_man_q    <= acc_man_d;
            acc_inf_q    <= acc_inf_d;
            op_q         <= op_d;
            last_q       <= last_d;
            byp_q        <= byp_d;
            a_sign_q     <= a_sign_d;
            b_sign_q     <= b_sign_d;
            a_exp_q      <= a_exp_d;
            a_man_q      <= a_man_d;
            b_man_q      <= b_man_d;
            sum_sign_q   <= sum_sign_d;
            sum_exp_q    <= sum_exp_d;
            sum_q        <= sum_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            term_count_q <= term_count_d;
        end
    end

    assign prod_ready_o = ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign term_count_o = term_count_q;

endmodule

// File: tb/tb_float_accumulator.sv
// tb_float_accumulator: directed bench for float_accumulator.
// Expected sums come from a signed-integer reference model, itself pinned by hand-computed literals.
module tb_float_accumulator;
    localparam int unsigned COUNT_W = 16;
`ifdef FACC_ROUND_EN
    localparam logic [31:0] RND_LIT = 32'h3F800001;
`else
    localparam logic [31:0] RND_LIT = 32'h3F800000;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               prod_valid = 1'b0;
    logic               prod_ready;
    logic [31:0]        prod_data = 32'h0;
    logic               prod_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_data;
    logic [COUNT_W-1:0] term_count;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_data_q[$];
    int          exp_cnt_q[$];

    always #5 clk = ~clk;

    float_accumulator #(.GUARD_BITS(3), .COUNT_W(COUNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .prod_valid_i (prod_valid),
        .prod_ready_o (prod_ready),
        .prod_data_i  (prod_data),
        .prod_last_i  (prod_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .term_count_o (term_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Reference: exact signed sum of truncated-aligned significands, then normalize.
    function automatic logic [31:0] model_add(input logic [31:0] acc, input logic [31:0] x);
        longint ma, mx, s, mag, m, g;
        int     ea, ex, e, d;
        bit     neg;
        if (acc[30:23] == 8'hFF) return acc;
        if (x[30:23] == 8'hFF) return {x[31], 8'hFF, 23'h0};
        ea = int'(acc[30:23]);
        ex = int'(x[30:23]);
        ma = (ea == 0) ? 0 : longint'({1'b1, acc[22:0]}) * 8;
        mx = (ex == 0) ? 0 : longint'({1'b1, x[22:0]}) * 8;
        if (ex > ea) begin
            e = ex; d = ex - ea;
            ma = (d >= 27) ? 0 : (ma >> d);
        end else begin
            e = ea; d = ea - ex;
            mx = (d >= 27) ? 0 : (mx >> d);
        end
        s   = (acc[31] ? -ma : ma) + (x[31] ? -mx : mx);
        neg = (s < 0);
        mag = neg ? -s : s;
        if (mag == 0) return 32'h0;
        while (mag >= 134217728) begin mag = mag >> 1; e++; end
        while (mag < 67108864) begin mag = mag << 1; e--; end
        m = mag >> 3;
        g = mag & 7;
`ifdef FACC_ROUND_EN
        if (g > 4 || (g == 4 && m[0])) m++;
        if (m >= 16777216) begin m = m >> 1; e++; end
`endif
        if (g < 0) m = 0;
        if (e <= 0) return 32'h0;
        if (e >= 255) return {neg, 8'hFF, 23'h0};
        return {neg, 8'(e), 23'(m)};
    endfunction

    task automatic send(input logic [31:0] w, input logic last);
        int n = 0;
        while (!prod_ready && n < 20) begin @(posedge clk); #1; n++; end
        tests++;
        if (!prod_ready) begin
            fails++;
            $display("FAIL send: prod_ready still 0 after %0d cycles, required 1", n);
            return;
        end
        prod_valid = 1'b1;
        prod_data  = w;
        prod_last  = last;
        @(posedge clk); #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        prod_data  = 32'hDEADBEEF;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_data_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
        tests++;
        if (exp_data_q.size() != 0) begin
            fails++;
            $display("FAIL %s drain: %0d results outstanding, required 0", name, exp_data_q.size());
            exp_data_q.delete();
            exp_cnt_q.delete();
        end
    endtask

    task automatic run_sum(input string name, input int n, input logic [31:0] t0, t1, t2,
                           input logic [31:0] lit, input bit chk_lat);
        logic [31:0] tv [3];
        logic [31:0] m;
        tv = '{t0, t1, t2};
        m  = 32'h0;
        for (int i = 0; i < n; i++) m = model_add(m, tv[i]);
        chk({name, " model"}, m, lit);
        exp_data_q.push_back(m);
        exp_cnt_q.push_back(n);
        for (int i = 0; i < n; i++) send(tv[i], (i == n - 1));
        if (chk_lat) begin
            repeat (2) begin @(posedge clk); #1; end
            chk({name, " out_valid early"}, 32'(out_valid), 32'h0);
            @(posedge clk); #1;
            chk({name, " out_valid latency"}, 32'(out_valid), 32'h1);
        end
        drain(name);
    endtask

    // Result checker: every cycle out_valid is high the outputs must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_data_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out: out_valid=1 with data %h, required no result pending", out_data);
            end else begin
                chk("out_data", out_data, exp_data_q[0]);
                chk("term_count", 32'(term_count), 32'(exp_cnt_q[0]));
                chk("prod_ready while out_valid", 32'(prod_ready), 32'h0);
                if (out_ready) begin
                    void'(exp_data_q.pop_front());
                    void'(exp_cnt_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] m;
        int          n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset prod_ready", 32'(prod_ready), 32'h1);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset term_count", 32'(term_count), 32'h0);

        // Reset held two cycles while the first term is in ALIGN
        send(32'h40000000, 1'b0);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        chk("midreset prod_ready", 32'(prod_ready), 32'h1);
        chk("midreset out_valid", 32'(out_valid), 32'h0);
        chk("midreset out_data", out_data, 32'h0);
        chk("midreset term_count", 32'(term_count), 32'h0);

        run_sum("single", 1, 32'h3FC00000, 32'h0, 32'h0, 32'h3FC00000, 1'b1);
        run_sum("three", 3, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40600000, 1'b1);
        run_sum("cancel", 2, 32'h40400000, 32'hC0400000, 32'h0, 32'h00000000, 1'b0);
        run_sum("diff25", 2, 32'h3F800000, 32'h33000000, 32'h0, 32'h3F800000, 1'b0);
        run_sum("diff27", 2, 32'h3F800000, 32'h32000000, 32'h0, 32'h3F800000, 1'b0);
        run_sum("ovf", 2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h7F800000, 1'b0);
        run_sum("inf sticky", 3, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF800000, 32'h7F800000, 1'b0);
        run_sum("inf first", 2, 32'hFF800000, 32'h7F800000, 32'h0, 32'hFF800000, 1'b0);
        run_sum("mixed", 3, 32'h40A00000, 32'hC0400000, 32'hBF800000, 32'h3F800000, 1'b0);
        run_sum("negative", 2, 32'hC1200000, 32'h40000000, 32'h0, 32'hC1000000, 1'b0);
        run_sum("denorm", 2, 32'h00400000, 32'h3F800000, 32'h0, 32'h3F800000, 1'b0);
        run_sum("underflow", 2, 32'h00C00000, 32'h80800000, 32'h0, 32'h00000000, 1'b0);
        run_sum("guard cancel", 2, 32'h3F800000, 32'hBF7FFFFF, 32'h0, 32'h33800000, 1'b0);
        run_sum("rounding", 2, 32'h3F800000, 32'h33C00000, 32'h0, RND_LIT, 1'b0);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        m = model_add(model_add(32'h0, 32'h40400000), 32'h3F800000);
        chk("bp model", m, 32'h40800000);
        exp_data_q.push_back(m);
        exp_cnt_q.push_back(2);
        send(32'h40400000, 1'b0);
        send(32'h3F800000, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 32'(out_valid), 32'h1);
            chk("bp prod_ready", 32'(prod_ready), 32'h0);
            chk("bp out_data", out_data, 32'h40800000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain("bp");
        run_sum("restart", 1, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 1'b1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
